prog_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the single-cycle CPU's instruction ROM. It receives a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them into consecutive instruction-memory word addresses. It holds the CPU in reset until a complete frame with a correct checksum has been written, then releases it.

---
 rtl/loader_pkg.sv | 17 +
 rtl/prog_loader_word_assembler.sv | 42 ++++
 rtl/prog_loader.sv | 158 +++++++++++++++
 tb/tb_prog_loader.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and defaults for the boot-time program loader.
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_e;

   localparam int          DEFAULT_ADDR_W = 7;
   localparam logic [7:0]  DEFAULT_MAGIC  = 8'hA5;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Collects four payload bytes into a little-endian 32-bit word; the completed
// word is presented combinationally alongside word_done on the 4th byte.
module word_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_out,
   output logic        word_done
);

   logic [1:0]  idx_q, idx_d;
   logic [31:0] lanes_q, lanes_d;

   always_comb begin
      idx_d   = idx_q;
      lanes_d = lanes_q;
      if (clear) begin
         idx_d   = '0;
         lanes_d = '0;
      end else if (byte_valid) begin
         idx_d = idx_q + 2'd1;
         lanes_d[{idx_q, 3'b000} +: 8] = byte_in;
      end
   end

   // word_out includes the byte arriving this cycle so the top can register it directly
   assign word_out  = lanes_d;
   assign word_done = byte_valid && !clear && (idx_q == 2'd3);

   always_ff @(posedge clk) begin
      if (!reset) begin
         idx_q   <= '0;
         lanes_q <= '0;
      end else begin
         idx_q   <= idx_d;
         lanes_q <= lanes_d;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes words into instruction memory and holds
// the CPU in reset until a frame with a matching XOR checksum has landed.
module prog_loader
   import loader_pkg::*;
#(
   parameter int         ADDR_W = DEFAULT_ADDR_W,
   parameter logic [7:0] MAGIC  = DEFAULT_MAGIC
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_run,
   output logic              load_err
);

   localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

   state_e            state_q, state_d;
   logic [7:0]        len_lo_q, len_lo_d;
   logic [15:0]       len_q, len_d;
   logic [15:0]       word_cnt_q, word_cnt_d;
   logic [7:0]        csum_q, csum_d;
   logic              rx_ready_q, rx_ready_d;
   logic              imem_we_q, imem_we_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]       imem_wdata_q, imem_wdata_d;
   logic              cpu_run_q, cpu_run_d;
   logic              load_err_q, load_err_d;

   logic              accept;
   logic              magic_seen;
   logic              data_byte;
   logic [31:0]       asm_word;
   logic              asm_done;
   logic [15:0]       len_in;

   assign accept     = rx_valid && rx_ready_q;
   assign magic_seen = accept && (state_q == IDLE) && (rx_data == MAGIC);
   assign data_byte  = accept && (state_q == DATA);
   assign len_in     = {rx_data, len_lo_q};

   word_assembler u_word_assembler (
      .clk        (clk),
      .reset      (reset),
      .clear      (magic_seen),
      .byte_valid (data_byte),
      .byte_in    (rx_data),
      .word_out   (asm_word),
      .word_done  (asm_done)
   );

   // Next-state, counters, checksum and registered-output values
   always_comb begin
      state_d      = state_q;
      len_lo_d     = len_lo_q;
      len_d        = len_q;
      word_cnt_d   = word_cnt_q;
      csum_d       = csum_q;
      imem_we_d    = 1'b0;
      imem_wdata_d = imem_wdata_q;
      imem_addr_d  = imem_we_q ? (imem_addr_q + ADDR_W'(1)) : imem_addr_q;

      case (state_q)
         IDLE: begin
            if (magic_seen) begin
               state_d = LEN0;
               csum_d  = '0;
            end
         end
         LEN0: begin
            if (accept) begin
               len_lo_d = rx_data;
               state_d  = LEN1;
            end
         end
         LEN1: begin
            if (accept) begin
               len_d       = len_in;
               word_cnt_d  = '0;
               imem_addr_d = '0;
               if ({1'b0, len_in} > MAX_WORDS) begin
                  state_d = ERR;
               end else if (len_in == 16'd0) begin
                  state_d = CSUM;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (data_byte) begin
               csum_d = csum_q ^ rx_data;
               if (asm_done) begin
                  imem_we_d    = 1'b1;
                  imem_wdata_d = asm_word;
                  word_cnt_d   = word_cnt_q + 16'd1;
                  if (word_cnt_d == len_q) begin
                     state_d = CSUM;
                  end
               end
            end
         end
         CSUM: begin
            if (accept) begin
               state_d = (rx_data == csum_q) ? DONE : ERR;
            end
         end
         DONE: state_d = DONE;
         ERR:  state_d = ERR;
         default: state_d = IDLE;
      endcase

      rx_ready_d = (state_d != DONE);
      cpu_run_d  = (state_d == DONE);
      load_err_d = (state_d == ERR);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         len_lo_q     <= '0;
         len_q        <= '0;
         word_cnt_q   <= '0;
         csum_q       <= '0;
         rx_ready_q   <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         cpu_run_q    <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_lo_q     <= len_lo_d;
         len_q        <= len_d;
         word_cnt_q   <= word_cnt_d;
         csum_q       <= csum_d;
         rx_ready_q   <= rx_ready_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         cpu_run_q    <= cpu_run_d;
         load_err_q   <= load_err_d;
      end
   end

   assign rx_ready   = rx_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign cpu_run    = cpu_run_q;
   assign load_err   = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as frames are
// sent and matched against each imem_we pulse.
module tb_prog_loader;

   logic        clk;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        imem_we;
   logic [6:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_run;
   logic        load_err;

   typedef struct packed {
      logic [6:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] frame_words[$];
   int          assertions = 0;
   int          failures   = 0;
   int          write_count = 0;
   logic        prev_we = 1'b0;

   prog_loader #(.ADDR_W(7), .MAGIC(8'hA5)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_run    (cpu_run),
      .load_err   (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every write strobe is matched against the oldest queued expectation
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         exp_t e;
         write_count++;
         assertions++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, required no write", imem_addr, imem_wdata);
         end else begin
            e = exp_q.pop_front();
            if (imem_addr !== e.addr || imem_wdata !== e.data) begin
               failures++;
               $display("[TB] FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                        imem_addr, imem_wdata, e.addr, e.data);
            end
         end
         assertions++;
         if (prev_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL we_width: imem_we high in consecutive cycles, required single-cycle pulse");
         end
      end
      prev_we = imem_we;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one byte and hold it until the DUT accepts it; returns at accept edge + 1
   task automatic send_byte(input logic [7:0] b, input int gap_pct);
      int waited = 0;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct)
         idle($urandom_range(1, 3));
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      while (rx_ready !== 1'b1 && waited < 1000) begin
         waited++;
         @(negedge clk);
      end
      if (rx_ready !== 1'b1) begin
         assertions++;
         failures++;
         $display("[TB] FAIL ready_timeout: rx_ready=%b, required 1 within 1000 cycles", rx_ready);
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   // Sends MAGIC, length and payload of frame_words; queues expected writes
   task automatic send_header_payload(input int gap_pct, output logic [7:0] csum);
      int          n;
      logic [31:0] w;
      logic [7:0]  bt;
      exp_t        e;
      n    = frame_words.size();
      csum = 8'h00;
      send_byte(8'hA5, gap_pct);
      send_byte(n[7:0], gap_pct);
      send_byte(n[15:8], gap_pct);
      for (int i = 0; i < n; i++) begin
         w = frame_words[i];
         for (int k = 0; k < 4; k++) begin
            bt   = w[8*k +: 8];
            csum = csum ^ bt;
            if (k == 3) begin
               e.addr = i[6:0];
               e.data = w;
               exp_q.push_back(e);
            end
            send_byte(bt, gap_pct);
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle(2);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      idle(3);
      @(negedge clk);
      assertions++;
      if (rx_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== 7'd0 || imem_wdata !== 32'd0
          || cpu_run !== 1'b0 || load_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_values: got ready=%b we=%b addr=%0d wdata=%h run=%b err=%b, required all 0",
                  rx_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_err);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      assertions++;
      if (rx_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ready_after_reset: got %b, required 1", rx_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_good_frame();
      logic [7:0] cs;
      int         w0;
      do_reset();
      w0 = write_count;
      frame_words = '{32'h20080013, 32'h20090001};
      send_header_payload(0, cs);
      assertions++;
      if (cs !== 8'h13) begin
         failures++;
         $display("[TB] FAIL good_csum_model: got %h, required 13", cs);
      end
      assertions++;
      if (cpu_run !== 1'b0) begin
         failures++;
         $display("[TB] FAIL run_before_csum: got %b, required 0", cpu_run);
      end
      send_byte(cs, 0);
      @(negedge clk);
      assertions++;
      if (cpu_run !== 1'b1 || load_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL good_run: got run=%b err=%b, required run=1 err=0", cpu_run, load_err);
      end
      assertions++;
      if (rx_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL good_ready_done: got %b, required 0", rx_ready);
      end
      assertions++;
      if (write_count - w0 !== 2 || exp_q.size() !== 0) begin
         failures++;
         $display("[TB] FAIL good_writes: got %0d writes, %0d pending, required 2 writes, 0 pending",
                  write_count - w0, exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_bad_csum();
      logic [7:0] cs;
      int         w0;
      do_reset();
      w0 = write_count;
      frame_words = '{32'h20080013, 32'h20090001};
      send_header_payload(0, cs);
      send_byte(8'h09, 0);
      @(negedge clk);
      assertions++;
      if (load_err !== 1'b1 || cpu_run !== 1'b0 || rx_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL bad_csum_err: got err=%b run=%b ready=%b, required err=1 run=0 ready=1",
                  load_err, cpu_run, rx_ready);
      end
      @(posedge clk);
      #1;
      send_byte(8'hA5, 0);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      idle(3);
      @(negedge clk);
      assertions++;
      if (load_err !== 1'b1 || cpu_run !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bad_csum_sticky: got err=%b run=%b, required err=1 run=0", load_err, cpu_run);
      end
      assertions++;
      if (write_count - w0 !== 2 || exp_q.size() !== 0) begin
         failures++;
         $display("[TB] FAIL bad_csum_writes: got %0d writes, %0d pending, required 2 writes, 0 pending",
                  write_count - w0, exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_garbage_empty();
      int w0;
      do_reset();
      w0 = write_count;
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      send_byte(8'h5A, 0);
      send_byte(8'hA5, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      @(negedge clk);
      assertions++;
      if (cpu_run !== 1'b1 || load_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL empty_run: got run=%b err=%b, required run=1 err=0", cpu_run, load_err);
      end
      assertions++;
      if (write_count !== w0) begin
         failures++;
         $display("[TB] FAIL empty_writes: got %0d writes, required 0", write_count - w0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_oversize();
      int w0;
      do_reset();
      w0 = write_count;
      send_byte(8'hA5, 0);
      send_byte(8'h81, 0);
      @(negedge clk);
      assertions++;
      if (load_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL oversize_early: got err=%b, required 0 before LEN_H", load_err);
      end
      @(posedge clk);
      #1;
      send_byte(8'h00, 0);
      @(negedge clk);
      assertions++;
      if (load_err !== 1'b1 || cpu_run !== 1'b0) begin
         failures++;
         $display("[TB] FAIL oversize_err: got err=%b run=%b, required err=1 run=0", load_err, cpu_run);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) send_byte(8'(i * 37), 0);
      idle(2);
      assertions++;
      if (write_count !== w0) begin
         failures++;
         $display("[TB] FAIL oversize_writes: got %0d writes, required 0", write_count - w0);
      end
   endtask

   task automatic test_full_random();
      logic [7:0] cs;
      int         w0;
      do_reset();
      w0 = write_count;
      frame_words = {};
      for (int i = 0; i < 128; i++) frame_words.push_back($urandom);
      send_header_payload(30, cs);
      send_byte(cs, 30);
      @(negedge clk);
      assertions++;
      if (cpu_run !== 1'b1 || load_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL full_run: got run=%b err=%b, required run=1 err=0", cpu_run, load_err);
      end
      assertions++;
      if (write_count - w0 !== 128 || exp_q.size() !== 0) begin
         failures++;
         $display("[TB] FAIL full_writes: got %0d writes, %0d pending, required 128 writes, 0 pending",
                  write_count - w0, exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] cs;
      exp_t       e;
      do_reset();
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      e.addr = 7'd0;
      e.data = 32'h44332211;
      exp_q.push_back(e);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      assertions++;
      if (rx_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== 7'd0 || imem_wdata !== 32'd0
          || cpu_run !== 1'b0 || load_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midreset_values: got ready=%b we=%b addr=%0d wdata=%h run=%b err=%b, required all 0",
                  rx_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_err);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      frame_words = '{32'hDEADBEEF};
      send_header_payload(0, cs);
      send_byte(cs, 0);
      @(negedge clk);
      assertions++;
      if (cpu_run !== 1'b1 || exp_q.size() !== 0) begin
         failures++;
         $display("[TB] FAIL midreset_reload: got run=%b pending=%0d, required run=1 pending=0",
                  cpu_run, exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_garbage_empty();
      test_oversize();
      test_full_random();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
